// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode, FSM state and operand-class enums,
// plus width-parametrised special-value constants.
package fpu_pkg;

  typedef enum logic [2:0] {
    FRM_RNE = 3'b000,
    FRM_RTZ = 3'b001,
    FRM_RDN = 3'b010,
    FRM_RUP = 3'b011,
    FRM_RMM = 3'b100
  } frm_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_RND
  } state_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } cls_e;

  // Positive quiet NaN with only the fraction MSB set; callers truncate to their width.
  function automatic logic [63:0] canon_nan(input int unsigned ew, input int unsigned mw);
    logic [63:0] ones;
    ones = (64'(1) << ew) - 64'(1);
    return (ones << mw) | (64'(1) << (mw - 1));
  endfunction

  // Largest finite magnitude (exponent all-ones minus one, fraction all-ones), sign excluded.
  function automatic logic [63:0] max_finite(input int unsigned ew, input int unsigned mw);
    logic [63:0] ones;
    ones = (64'(1) << ew) - 64'(1);
    return ((ones - 64'(1)) << mw) | ((64'(1) << mw) - 64'(1));
  endfunction

  // Subnormals fall into CLS_ZERO (denormals-are-zero).
  function automatic cls_e classify(input logic exp_zero, input logic exp_ones,
                                    input logic man_zero, input logic man_msb);
    if (exp_zero) return CLS_ZERO;
    if (!exp_ones) return CLS_NORM;
    if (man_zero) return CLS_INF;
    if (man_msb) return CLS_QNAN;
    return CLS_SNAN;
  endfunction

endpackage

// File: rtl/fpu_round.sv
// Round-increment decision from sign, lsb and guard/round/sticky bits.
// RMM support is compiled in only when FPU_MUL_RMM_EN is defined.
module fpu_round
  import fpu_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       round,
  input  logic       sticky,
  input  logic [2:0] frm,
  output logic       inc_c
);

  always_comb begin
    inc_c = 1'b0;
    case (frm)
      FRM_RNE: inc_c = guard & (lsb | round | sticky);
      FRM_RDN: inc_c = sign & (guard | round | sticky);
      FRM_RUP: inc_c = ~sign & (guard | round | sticky);
`ifdef FPU_MUL_RMM_EN
      FRM_RMM: inc_c = guard;
`endif
      default: inc_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_mul_param.sv
// Parametrised 3-cycle IEEE-754 multiplier (MUL -> NORM -> RND) with start/done/busy handshake.
// Define FPU_MUL_RMM_EN to enable round-to-nearest-max-magnitude for frm=100.
module fpu_mul_param
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] operA,
  input  logic [EXP_W+MAN_W:0] operB,
  input  logic [2:0]           frm,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done,
  output logic                 busy,
  output logic                 flag_nv,
  output logic                 flag_of,
  output logic                 flag_uf,
  output logic                 flag_nx
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned FW   = W - 1;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned MW1  = MAN_W + 1;
  localparam int unsigned PW   = 2 * MW1;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         NAN_C    = W'(canon_nan(EXP_W, MAN_W));
  localparam logic [FW-1:0]        MAXF_C   = FW'(max_finite(EXP_W, MAN_W));
  localparam logic [PW-1:0]        LOW_MASK = PW'((64'(1) << (MAN_W - 2)) - 64'(1));

  state_e state, state_nx;

  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;
  cls_e               a_cls, b_cls, a_cls_c, b_cls_c;
  logic [2:0]         frm_q;

  logic               sign_q;
  logic signed [EW-1:0] exp_q;
  logic [PW-1:0]      prod_q;
  logic [MAN_W-1:0]   frac_q;
  logic               g_q, r_q, s_q;

  logic               low_sticky_c;
  logic               inc_c, carry_c, frm_ok_c, ovf_inf_c;
  logic [MAN_W-1:0]   frac_r_c;
  logic signed [EW-1:0] exp_r_c;
  logic [W-1:0]       res_c;
  logic               nv_c, of_c, uf_c, nx_c;

  assign a_cls_c = classify(operA[W-2:MAN_W] == '0, &operA[W-2:MAN_W],
                            operA[MAN_W-1:0] == '0, operA[MAN_W-1]);
  assign b_cls_c = classify(operB[W-2:MAN_W] == '0, &operB[W-2:MAN_W],
                            operB[MAN_W-1:0] == '0, operB[MAN_W-1]);

  // State register; busy mirrors the next state so it is available as a flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_MUL;
      ST_MUL:  state_nx = ST_NORM;
      ST_NORM: state_nx = ST_RND;
      ST_RND:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign low_sticky_c = |(prod_q & LOW_MASK);

  // Datapath pipeline registers, advanced one stage per FSM state.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_sign <= operA[W-1];
          b_sign <= operB[W-1];
          a_exp  <= operA[W-2:MAN_W];
          b_exp  <= operB[W-2:MAN_W];
          a_man  <= operA[MAN_W-1:0];
          b_man  <= operB[MAN_W-1:0];
          a_cls  <= a_cls_c;
          b_cls  <= b_cls_c;
          frm_q  <= frm;
        end
      end
      ST_MUL: begin
        sign_q <= a_sign ^ b_sign;
        exp_q  <= EW'({2'b00, a_exp}) + EW'({2'b00, b_exp}) - EW'(BIAS);
        prod_q <= PW'({1'b1, a_man}) * PW'({1'b1, b_man});
      end
      ST_NORM: begin
        if (prod_q[PW-1]) begin
          frac_q <= prod_q[PW-2:MAN_W+1];
          g_q    <= prod_q[MAN_W];
          r_q    <= prod_q[MAN_W-1];
          s_q    <= prod_q[MAN_W-2] | low_sticky_c;
          exp_q  <= exp_q + EW'(1);
        end else begin
          frac_q <= prod_q[PW-3:MAN_W];
          g_q    <= prod_q[MAN_W-1];
          r_q    <= prod_q[MAN_W-2];
          s_q    <= low_sticky_c;
        end
      end
      default: ;
    endcase
  end

  fpu_round u_round (
    .sign   (sign_q),
    .lsb    (frac_q[0]),
    .guard  (g_q),
    .round  (r_q),
    .sticky (s_q),
    .frm    (frm_q),
    .inc_c  (inc_c)
  );

  // Rounding, special-case selection and exception flags for the RND stage.
  always_comb begin
    res_c = '0;
    nv_c  = 1'b0;
    of_c  = 1'b0;
    uf_c  = 1'b0;
    nx_c  = 1'b0;
    {carry_c, frac_r_c} = {1'b0, frac_q} + MW1'(inc_c);
    exp_r_c = exp_q + EW'(carry_c);
`ifdef FPU_MUL_RMM_EN
    frm_ok_c = (frm_q <= FRM_RMM);
`else
    frm_ok_c = (frm_q <= FRM_RUP);
`endif
    ovf_inf_c = (frm_q == FRM_RNE) || (frm_q == FRM_RMM) ||
                ((frm_q == FRM_RUP) && !sign_q) || ((frm_q == FRM_RDN) && sign_q);

    if (!frm_ok_c) begin
      res_c = NAN_C;
      nv_c  = 1'b1;
    end else if (a_cls == CLS_QNAN || a_cls == CLS_SNAN ||
                 b_cls == CLS_QNAN || b_cls == CLS_SNAN) begin
      res_c = NAN_C;
      nv_c  = (a_cls == CLS_SNAN) || (b_cls == CLS_SNAN);
    end else if ((a_cls == CLS_INF && b_cls == CLS_ZERO) ||
                 (a_cls == CLS_ZERO && b_cls == CLS_INF)) begin
      res_c = NAN_C;
      nv_c  = 1'b1;
    end else if (a_cls == CLS_INF || b_cls == CLS_INF) begin
      res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_cls == CLS_ZERO || b_cls == CLS_ZERO) begin
      res_c = {sign_q, {FW{1'b0}}};
    end else if (exp_r_c >= EXP_MAX) begin
      res_c = ovf_inf_c ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_q, MAXF_C};
      of_c  = 1'b1;
      nx_c  = 1'b1;
    end else if (exp_r_c[EW-1] || exp_r_c == '0) begin
      res_c = {sign_q, {FW{1'b0}}};
      uf_c  = 1'b1;
      nx_c  = 1'b1;
    end else begin
      res_c = {sign_q, exp_r_c[EXP_W-1:0], frac_r_c};
      nx_c  = g_q | r_q | s_q;
    end
  end

  // Result and flags are held between completions; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      done    <= 1'b0;
      flag_nv <= 1'b0;
      flag_of <= 1'b0;
      flag_uf <= 1'b0;
      flag_nx <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_RND) begin
        done    <= 1'b1;
        result  <= res_c;
        flag_nv <= nv_c;
        flag_of <= of_c;
        flag_uf <= uf_c;
        flag_nx <= nx_c;
      end
    end
  end

endmodule
